// File: rtl/mult_operand_feeder.sv
// Operand sequencer for mult32x32: buffers operand pairs in a FIFO and issues them one
// at a time as registered start pulses. Defining MULT_FEEDER_STATS_EN adds issued_count.
module mult_operand_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_a,
    input  logic [31:0]                  in_b,
    output logic                         mul_start,
    output logic [31:0]                  mul_a,
    output logic [31:0]                  mul_b,
    input  logic                         mul_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef MULT_FEEDER_STATS_EN
    ,
    output logic [15:0]                  issued_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_mul_start;
    logic [31:0]   r_mul_a;
    logic [31:0]   r_mul_b;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_issue;
    logic [63:0]   w_head;

    // in_ready depends only on the registered count, never on in_valid.
    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign in_ready   = !w_full;
    assign fifo_count = r_count;
    assign mul_start  = r_mul_start;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;

    // NOTE: storage is deliberately not reset; the count and pointers alone decide
    // which entries are valid, so a reset here would only cost area and fanout.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !mul_busy) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (mul_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!mul_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mul_start <= w_issue;
            if (w_issue) begin
                r_mul_a <= w_head[63:32];
                r_mul_b <= w_head[31:0];
            end
        end
    end

`ifdef MULT_FEEDER_STATS_EN
    logic [15:0] r_issued_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued_count <= '0;
        end else if (w_issue) begin
            r_issued_count <= r_issued_count + 16'd1;
        end
    end

    assign issued_count = r_issued_count;
`endif

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Directed bench for mult_operand_feeder with a small behavioural mult32x32 model
// (fixed busy latency) attached to the start/busy/product handshake.
module tb_mult_operand_feeder;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_busy;
    logic [2:0]  fifo_count;
`ifdef MULT_FEEDER_STATS_EN
    logic [15:0] issued_count;
`endif

    logic        m_busy;
    logic        hold_busy = 1'b0;
    logic [63:0] product;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cnt;

    int passed = 0;
    int total  = 0;

    logic [63:0] q_ops[$];
    logic [63:0] q_prods[$];
    int          n_starts = 0;
    int          n_viol = 0;
    int          n_double = 0;
    int          max_count = 0;
    logic        prev_start = 1'b0;
    logic        prev_mbusy = 1'b0;

    assign mul_busy = m_busy | hold_busy;

    mult_operand_feeder #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_busy   (mul_busy),
        .fifo_count (fifo_count)
`ifdef MULT_FEEDER_STATS_EN
        ,
        .issued_count (issued_count)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: busy for MUL_LAT cycles after start, product valid as busy falls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            product <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else if (mul_start && !m_busy) begin
            m_a    <= mul_a;
            m_b    <= mul_b;
            m_busy <= 1'b1;
            m_cnt  <= MUL_LAT;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                product <= 64'(m_a) * 64'(m_b);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mul_start) begin
                n_starts++;
                q_ops.push_back({mul_a, mul_b});
                if (mul_busy) n_viol++;
                if (prev_start) n_double++;
            end
            if (prev_mbusy && !m_busy) q_prods.push_back(product);
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
        prev_start = mul_start;
        prev_mbusy = m_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_monitor();
        q_ops.delete();
        q_prods.delete();
        n_viol    = 0;
        n_double  = 0;
        max_count = 0;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        logic accepted;
        accepted = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (!accepted) $display("FAIL push_accept: pair %0d,%0d not accepted within 100 cycles", a, b);
        else passed++;
    endtask

    task automatic wait_prods(input int n);
        for (int i = 0; i < 300 && q_prods.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (q_prods.size() < n) $display("FAIL wait_products: got %0d products, required %0d", q_prods.size(), n);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %b want 0", mul_start); else passed++;
        total++; if (mul_a !== 32'd0) $display("FAIL rst_mul_a: got %0h want 0", mul_a); else passed++;
        total++; if (mul_b !== 32'd0) $display("FAIL rst_mul_b: got %0h want 0", mul_b); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); else passed++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit held_ok;
        clear_monitor();
        in_a = 32'd23; in_b = 32'd45; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (fifo_count !== 3'd1) $display("FAIL single_count_after_push: got %0d want 1", fifo_count); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL single_no_early_start: got %b want 0", mul_start); else passed++;
        @(posedge clk);
        #1;
        total++; if (mul_start !== 1'b1) $display("FAIL single_start: got %b want 1", mul_start); else passed++;
        total++; if ({mul_a, mul_b} !== {32'd23, 32'd45}) $display("FAIL single_operands: got %0d,%0d want 23,45", mul_a, mul_b); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); else passed++;
        @(posedge clk);
        #1;
        total++; if ({mul_start, mul_busy} !== 2'b01) $display("FAIL single_pulse_end: got start=%b busy=%b want 0,1", mul_start, mul_busy); else passed++;
        held_ok = 1'b1;
        for (int i = 0; i < 50 && mul_busy; i++) begin
            if (mul_a !== 32'd23 || mul_b !== 32'd45) held_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        total++; if (mul_busy !== 1'b0) $display("FAIL single_busy_timeout: busy still %b", mul_busy); else passed++;
        total++; if (!held_ok) $display("FAIL single_operands_held: got %0b want 1", held_ok); else passed++;
        @(posedge clk);
        #1;
        total++; if (product !== 64'd1035) $display("FAIL single_product: got %0d want 1035", product); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL single_one_start: got %b want 0", mul_start); else passed++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea [5] = '{32'd100, 32'd65535, 32'hFFFF_FFFF, 32'd12345, 32'd1000};
        logic [31:0] eb [5] = '{32'd7, 32'd65537, 32'd2, 32'd0, 32'd1000};
        logic [63:0] ep [5] = '{64'd700, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_FFFF_FFFE, 64'd0, 64'd1000000};
        clear_monitor();
        for (int i = 0; i < 5; i++) push_pair(ea[i], eb[i]);
        total++; if (fifo_count !== 3'd4) $display("FAIL b2b_count_full: got %0d want 4", fifo_count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", in_ready); else passed++;
        wait_prods(5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (q_ops.size() <= i || q_ops[i] !== {ea[i], eb[i]})
                $display("FAIL b2b_operands[%0d]: got %0h want %0h", i, (q_ops.size() > i) ? q_ops[i] : 64'hx, {ea[i], eb[i]});
            else passed++;
            total++;
            if (q_prods.size() <= i || q_prods[i] !== ep[i])
                $display("FAIL b2b_product[%0d]: got %0h want %0h", i, (q_prods.size() > i) ? q_prods[i] : 64'hx, ep[i]);
            else passed++;
        end
        total++; if (n_viol != 0) $display("FAIL b2b_start_while_busy: got %0d want 0", n_viol); else passed++;
        total++; if (n_double != 0) $display("FAIL b2b_start_width: got %0d long pulses want 0", n_double); else passed++;
        total++; if (max_count > 4) $display("FAIL b2b_max_count: got %0d want <=4", max_count); else passed++;
    endtask

    // Busy held externally keeps the FSM in IDLE so the FIFO fills; then the held push must wait.
    task automatic test_full();
        logic [31:0] ea [5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hDEAD_BEEF};
        logic [31:0] eb [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        int starts0;
        clear_monitor();
        starts0   = n_starts;
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(ea[i], eb[i]);
        in_a = ea[4]; in_b = eb[4]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({in_ready, fifo_count} !== {1'b0, 3'd4})
                $display("FAIL full_blocked[%0d]: got ready=%b count=%0d want 0,4", i, in_ready, fifo_count);
            else passed++;
            @(posedge clk);
            #1;
        end
        total++; if (n_starts != starts0) $display("FAIL busy_idle_no_issue: got %0d starts want 0", n_starts - starts0); else passed++;
        hold_busy = 1'b0;
        @(posedge clk);
        #1;
        total++; if ({in_ready, fifo_count, mul_start} !== {1'b1, 3'd3, 1'b1})
            $display("FAIL full_first_pop: got ready=%b count=%0d start=%b want 1,3,1", in_ready, fifo_count, mul_start);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (fifo_count !== 3'd4) $display("FAIL full_late_accept: got %0d want 4", fifo_count); else passed++;
        wait_prods(5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (q_ops.size() <= i || q_ops[i] !== {ea[i], eb[i]})
                $display("FAIL full_order[%0d]: got %0h want %0h", i, (q_ops.size() > i) ? q_ops[i] : 64'hx, {ea[i], eb[i]});
            else passed++;
        end
        total++; if (max_count > 4) $display("FAIL full_max_count: got %0d want <=4", max_count); else passed++;
    endtask

    task automatic test_reset_mid();
        int starts0;
        clear_monitor();
        push_pair(32'd11, 32'd12);
        push_pair(32'd13, 32'd14);
        push_pair(32'd15, 32'd16);
        total++; if ({fifo_count, mul_busy} !== {3'd2, 1'b1}) $display("FAIL mid_setup: got count=%0d busy=%b want 2,1", fifo_count, mul_busy); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (mul_start !== 1'b0) $display("FAIL mid_rst_mul_start: got %b want 0", mul_start); else passed++;
        total++; if ({mul_a, mul_b} !== 64'd0) $display("FAIL mid_rst_operands: got %0h,%0h want 0,0", mul_a, mul_b); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL mid_rst_count: got %0d want 0", fifo_count); else passed++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        starts0 = n_starts;
        repeat (10) @(posedge clk);
        #1;
        total++; if (n_starts != starts0) $display("FAIL mid_no_start_after_reset: got %0d starts want 0", n_starts - starts0); else passed++;
        clear_monitor();
        push_pair(32'd6, 32'd7);
        wait_prods(1);
        total++; if (q_ops.size() != 1 || q_ops[0] !== {32'd6, 32'd7}) $display("FAIL mid_new_issue: got %0d issues want one of 6,7", q_ops.size()); else passed++;
        total++; if (q_prods.size() < 1 || q_prods[0] !== 64'd42) $display("FAIL mid_new_product: got %0d want 42", (q_prods.size() > 0) ? q_prods[0] : 64'hx); else passed++;
    endtask

`ifdef MULT_FEEDER_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_monitor();
        for (int i = 0; i < 3; i++) push_pair(32'(i + 2), 32'd3);
        wait_prods(3);
        total++; if (issued_count !== 16'd3) $display("FAIL stats_count: got %0d want 3", issued_count); else passed++;
        force dut.r_issued_count = 16'hFFFF;
        #1;
        release dut.r_issued_count;
        push_pair(32'd9, 32'd9);
        @(posedge clk);
        #1;
        total++; if (issued_count !== 16'd0) $display("FAIL stats_wrap: got %0h want 0", issued_count); else passed++;
        wait_prods(1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
`ifdef MULT_FEEDER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
